// File: rtl/rob_pkg.sv
// rob_pkg: shared types for the read-response return path.
//   r_beat_t    - one buffered R beat {id, data, resp, last, tagid}
//   RESP_DECERR - response code forced on beats whose tag has no live mapping
package rob_pkg;

  localparam int ROB_ID_WIDTH   = 4;
  localparam int ROB_DATA_WIDTH = 64;
  localparam int ROB_TAG_WIDTH  = 4;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0]   id;
    logic [ROB_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
    logic [ROB_TAG_WIDTH-1:0]  tagid;
  } r_beat_t;

endpackage

// File: rtl/r_if.sv
// r_if: AXI R-channel style bundle carrying the internal tag alongside the beat.
//   receiver - consumes beats (drives ready)
//   sender   - produces beats (drives valid and payload)
interface r_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4
) ();
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [1:0]            resp;
  logic                  last;
  logic [TAG_WIDTH-1:0]  tagid;

  modport receiver (input valid, tagid, data, resp, last, output ready);
  modport sender   (output valid, id, data, resp, last, tagid, input ready);
endinterface

// File: rtl/fifo.sv
// fifo: show-ahead synchronous FIFO (head word visible on rdata while !empty).
//   clk, rst (async, active-low)
//   push/wdata - write side, ignored when full
//   pop/rdata  - read side, ignored when empty
//   full/empty - occupancy flags
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  // DEPTH is a power of two so the pointers wrap naturally.
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr_reg;
  logic [AW-1:0]         rptr_reg;
  logic [AW:0]           count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + 1'b1;
      if (do_pop)  rptr_reg <= rptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/tag_id_table.sv
// tag_id_table: maps internal tags back to the original AXI ID.
//   alloc_valid/alloc_tag/alloc_id - record a mapping (sets vld)
//   rel_valid/rel_tag              - release a mapping (clears vld)
//   rd_tag -> rd_vld/rd_id         - asynchronous lookup of pre-edge state
//   dbl_alloc                      - alloc hit an entry that stays live this edge
module tag_id_table #(
  parameter int ID_WIDTH  = 4,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic [ID_WIDTH-1:0]  alloc_id,
  input  logic                 rel_valid,
  input  logic [TAG_WIDTH-1:0] rel_tag,
  input  logic [TAG_WIDTH-1:0] rd_tag,
  output logic                 rd_vld,
  output logic [ID_WIDTH-1:0]  rd_id,
  output logic                 dbl_alloc
);
  localparam int ENTRIES = 2**TAG_WIDTH;

  logic [ENTRIES-1:0] vld_vec;
  logic [ID_WIDTH-1:0] id_vec [ENTRIES];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic                vld_reg;
    logic [ID_WIDTH-1:0] id_reg;

    // Alloc takes priority so a same-edge release+alloc leaves the entry live.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_reg <= 1'b0;
        id_reg  <= '0;
      end else if (alloc_valid && alloc_tag == TAG_WIDTH'(gi)) begin
        vld_reg <= 1'b1;
        id_reg  <= alloc_id;
      end else if (rel_valid && rel_tag == TAG_WIDTH'(gi)) begin
        vld_reg <= 1'b0;
      end
    end

    assign vld_vec[gi] = vld_reg;
    assign id_vec[gi]  = id_reg;
  end

  assign rd_vld = vld_vec[rd_tag];
  assign rd_id  = id_vec[rd_tag];

  // A release of the same tag on this edge frees the entry, so no error.
  assign dbl_alloc = alloc_valid && vld_vec[alloc_tag] &&
                     !(rel_valid && rel_tag == alloc_tag);
endmodule

// File: rtl/outgoing_response_buffer.sv
// outgoing_response_buffer: return path for read data.
//   clk, rst (async, active-low)
//   alloc_valid/alloc_tag/alloc_id - tag->ID mapping issued by the request side
//   in_if  (receiver)              - tagged R beats from the internal side
//   out_if (sender)                - R beats with restored ID toward the AXI master
//   free_valid/free_tag            - one-cycle tag release after the last beat
//   err                            - sticky: double alloc or beat on a dead tag
module outgoing_response_buffer
  import rob_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic [ID_WIDTH-1:0]  alloc_id,
  r_if.receiver                in_if,
  r_if.sender                  out_if,
  output logic                 free_valid,
  output logic [TAG_WIDTH-1:0] free_tag,
  output logic                 err
);
  r_beat_t             push_beat;
  r_beat_t             fifo_head;
  r_beat_t             out_reg;
  logic                out_valid_reg;
  logic                free_valid_reg;
  logic [TAG_WIDTH-1:0] free_tag_reg;
  logic                err_reg;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                rel_fire;
  logic                lk_vld;
  logic [ID_WIDTH-1:0] lk_id;
  logic                dbl_alloc;

  // Ready is held low while reset is asserted, not just when full.
  assign in_if.ready = rst && !fifo_full;
  assign push        = in_if.valid && in_if.ready;
  assign pop         = !fifo_empty && (!out_valid_reg || out_if.ready);
  assign rel_fire    = out_valid_reg && out_if.ready && out_reg.last;

  tag_id_table #(
    .ID_WIDTH  (ID_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_tag   (alloc_tag),
    .alloc_id    (alloc_id),
    .rel_valid   (rel_fire),
    .rel_tag     (out_reg.tagid),
    .rd_tag      (in_if.tagid),
    .rd_vld      (lk_vld),
    .rd_id       (lk_id),
    .dbl_alloc   (dbl_alloc)
  );

  // Unmapped tags still flow through (with the stale ID) so the master sees
  // a DECERR beat instead of a hang.
  always_comb begin
    push_beat       = '0;
    push_beat.id    = lk_id;
    push_beat.data  = in_if.data[DATA_WIDTH-1:0];
    push_beat.resp  = lk_vld ? in_if.resp : RESP_DECERR;
    push_beat.last  = in_if.last;
    push_beat.tagid = in_if.tagid;
  end

  fifo #(
    .DATA_WIDTH ($bits(r_beat_t)),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_beat),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg  <= 1'b0;
      out_reg        <= '0;
      free_valid_reg <= 1'b0;
      free_tag_reg   <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (pop) begin
        out_reg       <= fifo_head;
        out_valid_reg <= 1'b1;
      end else if (out_if.ready) begin
        out_valid_reg <= 1'b0;
      end
      free_valid_reg <= rel_fire;
      if (rel_fire) free_tag_reg <= out_reg.tagid;
      if (dbl_alloc || (push && !lk_vld)) err_reg <= 1'b1;
    end
  end

  assign out_if.valid = out_valid_reg;
  assign out_if.id    = out_reg.id;
  assign out_if.data  = out_reg.data;
  assign out_if.resp  = out_reg.resp;
  assign out_if.last  = out_reg.last;
  assign out_if.tagid = out_reg.tagid;
  assign free_valid   = free_valid_reg;
  assign free_tag     = free_tag_reg;
  assign err          = err_reg;
endmodule
